// File: rtl/stacker_pkg.sv
// Shared encodings for the Stacker session controller: gamestate codes,
// FSM states and the default divider width.
package stacker_pkg;

  localparam int DIV_W = 24;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] GS_OVER = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_PLAY,
    ST_OVER
  } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronises one raw (already debounced) button into clk and emits a
// one-cycle pulse on its rising edge.
module btn_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STG-1:0] sync_q;
  logic                prev_q;

  // NOTE: registers update with <= so every flop samples pre-edge values,
  // which is what makes the shift chain a chain rather than one wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], btn};
      prev_q <= sync_q[SYNC_STG-1];
    end
  end

  assign pulse = sync_q[SYNC_STG-1] & ~prev_q;

endmodule

// File: rtl/stacker_session_ctrl.sv
// Stacker session sequencer: FSM, level-dependent game tick, place strobe latch.
// Optional macro TICK_SPEEDUP_EN shortens the tick period as game_level rises.
module stacker_session_ctrl #(
  parameter int               DIV_W    = stacker_pkg::DIV_W,
  parameter logic [DIV_W-1:0] BASE_DIV = DIV_W'(5_000_000),
  parameter logic [DIV_W-1:0] MIN_DIV  = DIV_W'(500_000),
  parameter int               ARM_CYC  = 4,
  parameter int               SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_place,
  input  logic       game_eog,
  input  logic [2:0] game_level,
  output logic [1:0] gamestate,
  output logic       game_tick,
  output logic       game_rst_n,
  output logic [2:0] buttons,
  output logic [7:0] session_cnt
);

  import stacker_pkg::*;

  localparam int ARM_W = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;

  state_t           state;
  logic             start_p;
  logic             place_p;
  logic             place_pend;
  logic [ARM_W-1:0] arm_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_next;
  logic             div_wrap;

  btn_sync_edge #(.SYNC_STG(SYNC_STG)) u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start),
    .pulse (start_p)
  );

  btn_sync_edge #(.SYNC_STG(SYNC_STG)) u_place_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_place),
    .pulse (place_p)
  );

`ifdef TICK_SPEEDUP_EN
  logic [DIV_W-1:0] shifted;

  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    shifted     = BASE_DIV >> game_level;
    period_next = (shifted < MIN_DIV) ? MIN_DIV : shifted;
  end
`else
  logic unused_level;
  assign unused_level = ^{game_level, MIN_DIV};
  assign period_next  = BASE_DIV;
`endif

  // period_q is only reloaded at a wrap, so a level change mid-tick waits.
  assign div_wrap = (div_cnt == period_q - DIV_W'(1));
  assign buttons  = {2'b00, place_pend};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gamestate   <= GS_IDLE;
      game_tick   <= 1'b0;
      game_rst_n  <= 1'b0;
      place_pend  <= 1'b0;
      session_cnt <= 8'd0;
      arm_cnt     <= '0;
      div_cnt     <= '0;
      period_q    <= BASE_DIV;
    end else begin
      game_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_p) begin
            state   <= ST_ARM;
            arm_cnt <= '0;
          end
        end
        ST_ARM: begin
          div_cnt  <= '0;
          period_q <= period_next;
          if (arm_cnt == ARM_W'(ARM_CYC - 1)) begin
            state      <= ST_PLAY;
            gamestate  <= GS_PLAY;
            game_rst_n <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end
        ST_PLAY: begin
          if (div_wrap) begin
            div_cnt   <= '0;
            period_q  <= period_next;
            game_tick <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
          // The engine samples place_pend during the tick cycle; a new press
          // landing in that same cycle must survive for the next tick.
          if (place_p) begin
            place_pend <= 1'b1;
          end else if (game_tick) begin
            place_pend <= 1'b0;
          end
          if (game_eog) begin
            state       <= ST_OVER;
            gamestate   <= GS_OVER;
            place_pend  <= 1'b0;
            session_cnt <= session_cnt + 8'd1;
          end
        end
        ST_OVER: begin
          if (start_p) begin
            state      <= ST_ARM;
            gamestate  <= GS_IDLE;
            game_rst_n <= 1'b0;
            arm_cnt    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
